// File: rtl/sim_stim_ctrl.sv
// Stimulus and supervision controller for the riscv_top bench.
// Sequences the CPU reset pulse, serialises queued bytes onto the CPU Rx
// line as start/data/stop frames, and runs a cycle watchdog that reports
// either DUT completion (done) or expiry (timeout).
module sim_stim_ctrl #(
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int BAUD_DIV       = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_valid,
    input  logic [DATA_BITS-1:0]          push_data,
    output logic                          push_ready,
    input  logic                          halt_in,
    output logic                          dut_rst,
    output logic                          rx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   cycle_cnt,
    output logic                          done,
    output logic                          timeout
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int RCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int BCW   = $clog2(STOP_BITS * BAUD_DIV);
    localparam int BIW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [RCW-1:0]   RST_LAST    = RCW'(RST_CYCLES - 1);
    localparam logic [BCW-1:0]   BIT_LAST    = BCW'(BAUD_DIV - 1);
    localparam logic [BCW-1:0]   STOP_LAST   = BCW'(STOP_BITS * BAUD_DIV - 1);
    localparam logic [BIW-1:0]   DATA_LAST   = BIW'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Reset sequencer state
    logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
    logic                 dut_rst_q, dut_rst_d;

    // Watchdog state
    logic [31:0]          cycle_cnt_q, cycle_cnt_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;

    // Byte queue state
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    // Serialiser state
    logic [1:0]           state_q, state_d;
    logic [BCW-1:0]       baud_q, baud_d;
    logic [BIW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 rx_q, rx_d;

    logic                 push_ready_s;
    logic                 push_fire_s;
    logic                 pop_s;
    logic                 start_ok_s;

    assign push_ready_s = (count_q != FULL_CNT);
    assign push_fire_s  = push_valid && push_ready_s;
    // A new frame may only begin while the CPU runs and the watchdog is quiet;
    // this also keeps the queue intact after done/timeout.
    assign start_ok_s   = (count_q != {CNT_W{1'b0}}) && !dut_rst_q && !done_q && !timeout_q;

    // Hold the CPU in reset for RST_CYCLES edges after rst_n release, then drop it for good
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        dut_rst_d = dut_rst_q;
        if (dut_rst_q) begin
            if (rst_cnt_q == RST_LAST) begin
                dut_rst_d = 1'b0;
            end else begin
                rst_cnt_d = rst_cnt_q + RCW'(1);
            end
        end else begin
            dut_rst_d = 1'b0;
        end
    end

    // Watchdog: count running cycles; halt wins over a simultaneous expiry
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        if (!dut_rst_q && !done_q && !timeout_q) begin
            if (halt_in) begin
                done_d = 1'b1;
            end else if ((cycle_cnt_q + 32'd1) >= TIMEOUT_VAL) begin
                timeout_d   = 1'b1;
                cycle_cnt_d = TIMEOUT_VAL;
            end else begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            end
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // Queue pointer and occupancy update; simultaneous push and pop cancel out
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_fire_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Frame serialiser: start bit, LSB-first data, stop bit(s), back-to-back when more is queued
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        rx_d    = rx_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rx_d = 1'b1;
                if (start_ok_s) begin
                    pop_s   = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                    baud_d  = {BCW{1'b0}};
                    rx_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_q == BIT_LAST) begin
                    state_d = ST_DATA;
                    baud_d  = {BCW{1'b0}};
                    bit_d   = {BIW{1'b0}};
                    rx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1'b1;
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d = {BCW{1'b0}};
                    if (bit_q == DATA_LAST) begin
                        state_d = ST_STOP;
                        rx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIW'(1);
                        rx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == STOP_LAST) begin
                    baud_d = {BCW{1'b0}};
                    if (start_ok_s) begin
                        pop_s   = 1'b1;
                        shreg_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        rx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        rx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = {BCW{1'b0}};
                rx_d    = 1'b1;
            end
        endcase
    end

    // Queue storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_fire_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // All control state; reset returns the line to idle immediately, even mid-frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q   <= {RCW{1'b0}};
            dut_rst_q   <= 1'b1;
            cycle_cnt_q <= 32'd0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            state_q     <= ST_IDLE;
            baud_q      <= {BCW{1'b0}};
            bit_q       <= {BIW{1'b0}};
            shreg_q     <= {DATA_BITS{1'b0}};
            rx_q        <= 1'b1;
        end else begin
            rst_cnt_q   <= rst_cnt_d;
            dut_rst_q   <= dut_rst_d;
            cycle_cnt_q <= cycle_cnt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            rx_q        <= rx_d;
        end
    end

    assign push_ready = push_ready_s;
    assign dut_rst    = dut_rst_q;
    assign rx_out     = rx_q;
    assign busy       = (state_q != ST_IDLE) || (count_q != {CNT_W{1'b0}});
    assign fifo_count = count_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_sim_stim_ctrl.sv
// Directed bench for sim_stim_ctrl. Instance A (long reset, long watchdog)
// covers the serial path; instance B (4-cycle reset, 100-cycle watchdog)
// covers reset sequencing, timeout and halt.
module tb_sim_stim_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, push_valid_a, halt_a;
    logic [7:0]  push_data_a;
    logic        push_ready_a, dut_rst_a, rx_a, busy_a, done_a, timeout_a;
    logic [2:0]  count_a;
    logic [31:0] cyc_a;

    logic        rst_n_b, push_valid_b, halt_b;
    logic [7:0]  push_data_b;
    logic        push_ready_b, dut_rst_b, rx_b, busy_b, done_b, timeout_b;
    logic [2:0]  count_b;
    logic [31:0] cyc_b;

    int checks = 0;
    int errors = 0;

    sim_stim_ctrl #(.RST_CYCLES(8), .TIMEOUT_CYCLES(2000), .BAUD_DIV(4),
                    .FIFO_DEPTH(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .push_valid(push_valid_a), .push_data(push_data_a),
        .push_ready(push_ready_a), .halt_in(halt_a), .dut_rst(dut_rst_a), .rx_out(rx_a),
        .busy(busy_a), .fifo_count(count_a), .cycle_cnt(cyc_a), .done(done_a),
        .timeout(timeout_a)
    );

    sim_stim_ctrl #(.RST_CYCLES(4), .TIMEOUT_CYCLES(100), .BAUD_DIV(4),
                    .FIFO_DEPTH(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .push_valid(push_valid_b), .push_data(push_data_b),
        .push_ready(push_ready_b), .halt_in(halt_b), .dut_rst(dut_rst_b), .rx_out(rx_b),
        .busy(busy_b), .fifo_count(count_b), .cycle_cnt(cyc_b), .done(done_b),
        .timeout(timeout_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles into a 40-cycle frame of byte b (BAUD_DIV=4)
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k < 4) begin
            return 1'b0;
        end else if (k < 36) begin
            return b[(k - 4) / 4];
        end else begin
            return 1'b1;
        end
    endfunction

    initial begin
        rst_n_a = 1'b0; push_valid_a = 1'b0; push_data_a = 8'h00; halt_a = 1'b0;
        rst_n_b = 1'b0; push_valid_b = 1'b0; push_data_b = 8'h00; halt_b = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check_val("rst_dut_rst", 32'(dut_rst_b), 32'd1);
        check_val("rst_rx",      32'(rx_b),      32'd1);
        check_val("rst_ready",   32'(push_ready_b), 32'd1);
        check_val("rst_busy",    32'(busy_b),    32'd0);
        check_val("rst_count",   32'(count_b),   32'd0);
        check_val("rst_cyc",     cyc_b,          32'd0);
        check_val("rst_done",    32'(done_b),    32'd0);
        check_val("rst_timeout", 32'(timeout_b), 32'd0);

        // ---------------- reset sequencing + timeout (B) ----------------
        rst_n_b = 1'b1;                         // edge 0
        for (int e = 1; e <= 4; e++) begin
            tick();
            check_val("seq_dut_rst", 32'(dut_rst_b), (e < 4) ? 32'd1 : 32'd0);
        end
        tick();                                 // edge 5
        check_val("seq_cyc1", cyc_b, 32'd1);
        for (int e = 6; e <= 103; e++) tick();
        check_val("to_cyc99", cyc_b, 32'd99);
        check_val("to_not_yet", 32'(timeout_b), 32'd0);
        tick();                                 // edge 104
        check_val("to_set", 32'(timeout_b), 32'd1);
        check_val("to_cyc100", cyc_b, 32'd100);
        check_val("to_done0", 32'(done_b), 32'd0);
        tick(); tick(); tick();
        check_val("to_hold", cyc_b, 32'd100);
        halt_b = 1'b1;
        tick();
        halt_b = 1'b0;
        check_val("to_halt_ignored", 32'(done_b), 32'd0);
        check_val("to_sticky", 32'(timeout_b), 32'd1);

        // ---------------- halt (B) ----------------
        rst_n_b = 1'b0;
        tick();
        rst_n_b = 1'b1;
        for (int e = 1; e <= 41; e++) tick();
        check_val("halt_cyc37", cyc_b, 32'd37);
        halt_b = 1'b1;
        tick();
        halt_b = 1'b0;
        check_val("halt_done", 32'(done_b), 32'd1);
        check_val("halt_freeze", cyc_b, 32'd37);
        push_valid_b = 1'b1; push_data_b = 8'h55;
        tick();
        push_valid_b = 1'b0;
        check_val("halt_queued", 32'(count_b), 32'd1);
        for (int j = 0; j < 150; j++) begin
            tick();
            check_val("halt_rx_idle", 32'(rx_b), 32'd1);
        end
        check_val("halt_sticky", 32'(done_b), 32'd1);
        check_val("halt_no_timeout", 32'(timeout_b), 32'd0);
        check_val("halt_cyc_frozen", cyc_b, 32'd37);
        check_val("halt_retained", 32'(count_b), 32'd1);
        check_val("halt_busy", 32'(busy_b), 32'd1);
        rst_n_b = 1'b0;

        // ---------------- single byte 0xA5 (A) ----------------
        rst_n_a = 1'b1;
        for (int e = 1; e <= 8; e++) tick();
        check_val("a_rel", 32'(dut_rst_a), 32'd0);
        push_valid_a = 1'b1; push_data_a = 8'hA5;
        tick();                                 // edge N
        push_valid_a = 1'b0;
        check_val("sb_count", 32'(count_a), 32'd1);
        check_val("sb_rx_pre", 32'(rx_a), 32'd1);
        for (int k = 0; k < 40; k++) begin
            tick();
            check_val("sb_rx", 32'(rx_a), 32'(frame_bit(8'hA5, k)));
        end
        check_val("sb_busy_last", 32'(busy_a), 32'd1);
        tick();
        check_val("sb_busy_end", 32'(busy_a), 32'd0);
        check_val("sb_rx_end", 32'(rx_a), 32'd1);

        // ---------------- back-to-back and full (A) ----------------
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;                         // edge 0
        push_valid_a = 1'b1; push_data_a = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            tick();                             // edge k pushes byte k
            push_data_a = 8'(k + 1);
            check_val("full_count", 32'(count_a), (k < 4) ? 32'(k) : 32'd4);
            check_val("full_ready", 32'(push_ready_a), (k < 4) ? 32'd1 : 32'd0);
        end
        push_valid_a = 1'b0;
        tick(); tick();                         // edges 7, 8
        check_val("b2b_rel", 32'(dut_rst_a), 32'd0);
        check_val("b2b_rx_pre", 32'(rx_a), 32'd1);
        for (int j = 0; j < 160; j++) begin
            tick();
            check_val("b2b_rx", 32'(rx_a), 32'(frame_bit(8'(j / 40 + 1), j % 40)));
        end
        tick();
        check_val("b2b_busy_end", 32'(busy_a), 32'd0);
        check_val("b2b_count_end", 32'(count_a), 32'd0);
        check_val("b2b_rx_end", 32'(rx_a), 32'd1);

        // ---------------- reset mid-frame (A) ----------------
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        push_valid_a = 1'b1;
        push_data_a = 8'h00; tick();
        push_data_a = 8'h22; tick();
        push_data_a = 8'h33; tick();
        push_valid_a = 1'b0;
        for (int e = 4; e <= 15; e++) tick();   // edge 15: inside data bit 0
        check_val("mf_rx_low", 32'(rx_a), 32'd0);
        check_val("mf_count2", 32'(count_a), 32'd2);
        #2;
        rst_n_a = 1'b0;
        #1;
        check_val("mf_rx_async", 32'(rx_a), 32'd1);
        check_val("mf_count_async", 32'(count_a), 32'd0);
        check_val("mf_busy_async", 32'(busy_a), 32'd0);
        check_val("mf_dut_rst_async", 32'(dut_rst_a), 32'd1);
        tick();
        rst_n_a = 1'b1;
        for (int j = 0; j < 60; j++) begin
            tick();
            check_val("mf_no_residue", 32'(rx_a), 32'd1);
        end
        check_val("mf_busy_after", 32'(busy_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
